// File: rtl/lrec_tp_if.sv
// Handshake bundle for the lrec_tp dual-rail token generator.
// The master side requests runs and acknowledges tokens; the slave side is the generator.
interface lrec_tp_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic                   start;
    logic [CNT_W-1:0]       n_terms;
    logic                   ack_i;
    logic [WIDTH-1:0][1:0]  out;
    logic                   busy;
    logic                   done;
    logic                   ovf;
    logic                   proto_err;

    modport master (
        output start, n_terms, ack_i,
        input  out, busy, done, ovf, proto_err
    );

    modport slave (
        input  start, n_terms, ack_i,
        output out, busy, done, ovf, proto_err
    );
endinterface

// File: rtl/lrec_tp.sv
// Linear-recurrence term generator (each term is the sum of the previous ORDER terms),
// emitted as dual-rail two-phase tokens to an asynchronous receiver.
//
// state | meaning
// IDLE  | waiting for start; n_terms sampled here
// EMIT  | toggle one rail per bit of w[0], count the token
// WAIT  | hold out until the receiver acknowledges
// DONE  | one-cycle done pulse, then back to IDLE
module lrec_tp #(
    parameter int WIDTH = 32,
    parameter int ORDER = 2,
    parameter int CNT_W = 16,
    parameter int SAT   = 0
) (
    input  logic    clk,
    input  logic    rst,
    lrec_tp_if.slave bus
);
    localparam int SUM_W = WIDTH + $clog2(ORDER);

    typedef enum logic [1:0] {IDLE, EMIT, WAIT, DONE} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       win [ORDER];
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       n_cap;
    logic                   ack_s1;
    logic                   ack_s2;
    logic                   ack_hist;
    logic                   ack_edge;
    logic [SUM_W-1:0]       sum;
    logic                   sum_ovf;
    logic [WIDTH-1:0]       next_term;
    logic [WIDTH-1:0][1:0]  out_q;
    logic [WIDTH-1:0][1:0]  tok_next;
    logic                   busy_q;
    logic                   done_q;
    logic                   ovf_q;
    logic                   perr_q;

    assign ack_edge = ack_s2 ^ ack_hist;

    always_comb begin
        sum = '0;
        for (int i = 0; i < ORDER; i++) begin
            sum = sum + SUM_W'(win[i]);
        end
    end

    assign sum_ovf = |sum[SUM_W-1:WIDTH];

    always_comb begin
        next_term = sum[WIDTH-1:0];
        if (sum_ovf && (SAT != 0)) begin
            next_term = '1;
        end
    end

    // Exactly one rail flips per bit: rail[1] for a one, rail[0] for a zero.
    always_comb begin
        tok_next = out_q;
        for (int b = 0; b < WIDTH; b++) begin
            tok_next[b] = out_q[b] ^ (win[0][b] ? 2'b10 : 2'b01);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            n_cap    <= '0;
            ack_s1   <= 1'b0;
            ack_s2   <= 1'b0;
            ack_hist <= 1'b0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            for (int i = 0; i < ORDER; i++) begin
                win[i] <= '0;
            end
        end else begin
            ack_s1   <= bus.ack_i;
            ack_s2   <= ack_s1;
            ack_hist <= ack_s2;
            done_q   <= 1'b0;

            // An acknowledge is only legal while a token is outstanding.
            if (ack_edge && (state != WAIT)) begin
                perr_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.n_terms != '0) begin
                            for (int i = 0; i < ORDER; i++) begin
                                win[i] <= (i == ORDER - 1) ? WIDTH'(1) : '0;
                            end
                            n_cap <= bus.n_terms;
                            cnt   <= '0;
                            state <= EMIT;
                        end else begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                EMIT: begin
                    out_q <= tok_next;
                    cnt   <= cnt + CNT_W'(1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (ack_edge) begin
                        if (cnt == n_cap) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            for (int i = 0; i < ORDER - 1; i++) begin
                                win[i] <= win[i+1];
                            end
                            win[ORDER-1] <= next_term;
                            if (sum_ovf) begin
                                ovf_q <= 1'b1;
                            end
                            state <= EMIT;
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ovf       = ovf_q;
    assign bus.proto_err = perr_q;
endmodule

// File: tb/tb_lrec_tp.sv
// Bench for lrec_tp: three configurations (order-2 wrap, order-2 saturate, order-3 wrap)
// driven by a randomized asynchronous receiver and compared against a recurrence model.
module tb_lrec_tp;
    localparam int W  = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                start_a [3];
    logic [CW-1:0]       n_a     [3];
    logic                ack_a   [3];
    logic [W-1:0][1:0]   out_a   [3];
    logic                busy_a  [3];
    logic                done_a  [3];
    logic                ovf_a   [3];
    logic                perr_a  [3];

    int     ord_a [3] = '{2, 2, 3};
    int     sat_a [3] = '{0, 1, 0};
    bit     model_ovf  [3];
    bit     model_perr [3];
    longint exp_tok [64];
    longint got_tok [64];
    int     n_checks = 0;
    int     n_fail   = 0;

    lrec_tp_if #(.WIDTH(W), .CNT_W(CW)) bus0 ();
    lrec_tp_if #(.WIDTH(W), .CNT_W(CW)) bus1 ();
    lrec_tp_if #(.WIDTH(W), .CNT_W(CW)) bus2 ();

    lrec_tp #(.WIDTH(W), .ORDER(2), .CNT_W(CW), .SAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    lrec_tp #(.WIDTH(W), .ORDER(2), .CNT_W(CW), .SAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    lrec_tp #(.WIDTH(W), .ORDER(3), .CNT_W(CW), .SAT(0)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus0.start = start_a[0];  assign bus0.n_terms = n_a[0];  assign bus0.ack_i = ack_a[0];
    assign bus1.start = start_a[1];  assign bus1.n_terms = n_a[1];  assign bus1.ack_i = ack_a[1];
    assign bus2.start = start_a[2];  assign bus2.n_terms = n_a[2];  assign bus2.ack_i = ack_a[2];
    assign out_a[0] = bus0.out;  assign busy_a[0] = bus0.busy;  assign done_a[0] = bus0.done;
    assign out_a[1] = bus1.out;  assign busy_a[1] = bus1.busy;  assign done_a[1] = bus1.done;
    assign out_a[2] = bus2.out;  assign busy_a[2] = bus2.busy;  assign done_a[2] = bus2.done;
    assign ovf_a[0] = bus0.ovf;  assign perr_a[0] = bus0.proto_err;
    assign ovf_a[1] = bus1.ovf;  assign perr_a[1] = bus1.proto_err;
    assign ovf_a[2] = bus2.ovf;  assign perr_a[2] = bus2.proto_err;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Sequence s[j] = sum of the ORDER preceding terms; a run of n tokens computes s[ORDER..n+ORDER-2].
    task automatic model_run(input int k, input int n);
        longint seq [80];
        longint raw;
        for (int j = 0; j < 80; j++) seq[j] = 0;
        seq[ord_a[k]-1] = 1;
        for (int j = ord_a[k]; j <= n + ord_a[k] - 2; j++) begin
            raw = 0;
            for (int i = j - ord_a[k]; i < j; i++) raw += seq[i];
            if (raw > 255) begin
                model_ovf[k] = 1'b1;
                seq[j] = (sat_a[k] != 0) ? 255 : raw % 256;
            end else begin
                seq[j] = raw;
            end
        end
        for (int j = 0; j < n; j++) exp_tok[j] = seq[j];
    endtask

    function automatic void decode(input logic [W-1:0][1:0] cur, input logic [W-1:0][1:0] old,
                                   output int val, output bit ok);
        logic [1:0] d;
        val = 0;
        ok  = 1'b1;
        for (int b = 0; b < W; b++) begin
            d = cur[b] ^ old[b];
            if (d == 2'b10) val |= (1 << b);
            else if (d != 2'b01) ok = 1'b0;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ack_a[k] = 1'b0;
            start_a[k] = 1'b0;
            model_ovf[k] = 1'b0;
            model_perr[k] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_val("rst_out", out_a[k], 0);
            check_val("rst_busy", busy_a[k], 0);
            check_val("rst_done", done_a[k], 0);
            check_val("rst_ovf", ovf_a[k], 0);
            check_val("rst_perr", perr_a[k], 0);
        end
    endtask

    // Receiver: decodes every token, acknowledges dly cycles later (random 1..8 when dly=0).
    task automatic run(input int k, input int n, input int dly, input bit poke, input bit coinc,
                       input int abort);
        logic [W-1:0][1:0] prev;
        int ntok, pend, cyc, v;
        bit ok, fin, poked;
        ntok = 0; pend = -1; cyc = 0; fin = 1'b0; poked = 1'b0;
        if (coinc) begin
            ack_a[k] = ~ack_a[k];
            @(negedge clk);
            @(negedge clk);
            model_perr[k] = 1'b1;
        end
        prev = out_a[k];
        start_a[k] = 1'b1;
        n_a[k] = CW'(n);
        @(negedge clk);
        start_a[k] = 1'b0;
        n_a[k] = CW'($urandom);
        while (!fin) begin
            start_a[k] = 1'b0;
            if (out_a[k] !== prev) begin
                decode(out_a[k], prev, v, ok);
                check_val("rail_enc", ok, 1);
                if (ntok < 64) got_tok[ntok] = v;
                ntok++;
                prev = out_a[k];
                pend = (dly > 0) ? dly : int'($urandom_range(1, 8));
            end
            if (poke && !poked && ntok >= 1) begin
                start_a[k] = 1'b1;
                n_a[k] = CW'(n + 3);
                poked = 1'b1;
            end
            if (done_a[k]) begin
                check_val("busy_at_done", busy_a[k], 1);
                @(negedge clk);
                start_a[k] = 1'b0;
                check_val("busy_fall", busy_a[k], 0);
                check_val("done_pulse", done_a[k], 0);
                fin = 1'b1;
            end else if (abort > 0 && ntok >= abort) begin
                fin = 1'b1;
            end else if (cyc > 3000) begin
                check_val("run_timeout", cyc, 0);
                fin = 1'b1;
            end else begin
                if (pend == 0) begin
                    ack_a[k] = ~ack_a[k];
                    pend = -1;
                end else if (pend > 0) begin
                    pend--;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start_a[k] = 1'b0;
        if (abort == 0) begin
            model_run(k, n);
            check_val("n_tok", ntok, n);
            for (int i = 0; i < n && i < ntok && i < 64; i++) check_val("tok", got_tok[i], exp_tok[i]);
            check_val("ovf", ovf_a[k], model_ovf[k]);
            check_val("perr", perr_a[k], model_perr[k]);
        end
    endtask

    task automatic hold_test(input int k);
        logic [W-1:0][1:0] prev, held;
        int v, changes, early, cyc;
        bit ok;
        prev = out_a[k];
        start_a[k] = 1'b1;
        n_a[k] = CW'(2);
        @(negedge clk);
        start_a[k] = 1'b0;
        cyc = 0;
        while (out_a[k] === prev && cyc < 20) begin @(negedge clk); cyc++; end
        decode(out_a[k], prev, v, ok);
        check_val("hold_tok0", v, 0);
        held = out_a[k];
        changes = 0;
        repeat (100) begin
            @(negedge clk);
            if (out_a[k] !== held) changes++;
        end
        check_val("hold_stable", changes, 0);
        check_val("hold_busy", busy_a[k], 1);
        ack_a[k] = ~ack_a[k];
        early = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_a[k] !== held) early++;
        end
        check_val("ack_lat_early", early, 0);
        @(negedge clk);
        check_val("ack_lat_edge", out_a[k] !== held, 1);
        decode(out_a[k], held, v, ok);
        check_val("hold_tok1", v, 1);
        ack_a[k] = ~ack_a[k];
        cyc = 0;
        while (!done_a[k] && cyc < 20) begin @(negedge clk); cyc++; end
        check_val("hold_done", done_a[k], 1);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            start_a[k] = 1'b0;
            n_a[k] = '0;
            ack_a[k] = 1'b0;
        end
        do_reset();

        run(0, 10, 5, 1'b0, 1'b0, 0);
        run(0, 16, 0, 1'b0, 1'b0, 0);
        check_val("wrap_t14", got_tok[14], 121);
        check_val("wrap_ovf", ovf_a[0], 1);
        run(1, 16, 0, 1'b0, 1'b0, 0);
        check_val("sat_t14", got_tok[14], 255);
        check_val("sat_t15", got_tok[15], 255);
        run(2, 7, 0, 1'b0, 1'b0, 0);
        check_val("o3_t6", got_tok[6], 7);

        hold_test(1);

        run(0, 10, 0, 1'b0, 1'b0, 4);
        do_reset();
        run(0, 3, 0, 1'b0, 1'b0, 0);

        run(2, 0, 0, 1'b0, 1'b0, 0);
        run(1, 6, 0, 1'b1, 1'b0, 0);

        repeat (12) begin
            run(int'($urandom_range(0, 2)), int'($urandom_range(1, 20)), 0,
                bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 0);
        end

        for (int k = 0; k < 3; k++) begin
            ack_a[k] = ~ack_a[k];
            repeat (6) @(negedge clk);
            check_val("idle_ack_perr", perr_a[k], 1);
            check_val("idle_ack_busy", busy_a[k], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lrec_tp.md
LREC_TP -- requirements
Module: lrec_tp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the term width in bits (2..64).
REQ-002 The block SHALL have parameter ORDER, default 2, meaning the number of preceding terms summed per new term (2..8).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the term-count request.
REQ-004 The block SHALL have parameter SAT, default 0, meaning 0 = wrap modulo 2^WIDTH and 1 = saturate at all-ones.
REQ-005 The block SHALL have port clk  in  1  meaning the single clock (all logic on rising edge).
REQ-006 The block SHALL have port rst  in  1  meaning reset, synchronous, active-high.
REQ-007 The block SHALL have port start  in  1  meaning the run request, sampled in IDLE only.
REQ-008 The block SHALL have port n_terms  in  CNT_W  meaning the number of tokens to emit, sampled with start.
REQ-009 The block SHALL have port ack_i  in  1  meaning the two-phase acknowledge from the asynchronous receiver, where each transition is one ack.
REQ-010 The block SHALL have port out  out  [WIDTH-1:0][1:0]  meaning the dual-rail two-phase token, with rail[1] carrying 1 and rail[0] carrying 0.
REQ-011 The block SHALL have port busy  out  1  meaning it is high in every state except IDLE.
REQ-012 The block SHALL have port done  out  1  meaning a one-cycle pulse at the end of a run.
REQ-013 The block SHALL have port ovf  out  1  meaning a sticky flag set when a computed term exceeds WIDTH bits.
REQ-014 The block SHALL have port proto_err  out  1  meaning a sticky flag set on an ack transition received outside WAIT.

Function
REQ-015 The block SHALL encode each token by toggling, per bit, exactly one rail: rail[1] if the bit is 1, rail[0] if the bit is 0; all bits toggle on the same edge.
REQ-016 The block SHALL pass ack_i through a 2-flop synchronizer plus one history flop, and SHALL treat ack_edge as sync2 XOR history.
REQ-017 The block SHALL hold a window w[0..ORDER-1] seeded as w[0..ORDER-2]=0 and w[ORDER-1]=1, and SHALL always emit w[0].
REQ-018 On advance, the block SHALL shift the window so that w[i]<=w[i+1], and SHALL load w[ORDER-1] with sum(w[0..ORDER-1]) computed at WIDTH+clog2(ORDER) bits.
REQ-019 If the upper sum bits are nonzero, the block SHALL set ovf and SHALL store the low WIDTH bits when SAT=0, or all-ones when SAT=1.
REQ-020 The block SHALL implement the FSM states IDLE, EMIT, WAIT and DONE.
REQ-021 In IDLE with start=1 and n_terms!=0, the block SHALL load the seeds, capture n_terms, clear cnt and go to EMIT.
REQ-022 In IDLE with start=1 and n_terms=0, the block SHALL go to DONE and emit no token.
REQ-023 In EMIT, the block SHALL toggle out per w[0], increment cnt and go to WAIT, so the first token changes out on the second edge after start is sampled.
REQ-024 In WAIT with ack_edge, the block SHALL go to DONE if cnt==captured n_terms; otherwise it SHALL advance the window and go to EMIT.
REQ-025 In WAIT without ack_edge, the block SHALL hold state and out indefinitely, with no timeout.
REQ-026 In DONE, the block SHALL assert done for exactly one cycle and then go to IDLE.
REQ-027 The block SHALL change out exactly 3 edges after the edge at which an ack_i transition is first captured by the synchronizer.
REQ-028 The block SHALL ignore start while busy, and SHALL ignore changes on n_terms after capture.
REQ-029 The block SHALL discard an ack_edge in IDLE, EMIT or DONE and SHALL set proto_err.
REQ-030 When ack_edge and start coincide in IDLE, the block SHALL start the run and set proto_err.
REQ-031 The block SHALL set ovf even when the overflowing term is never emitted; ovf and proto_err SHALL clear only on rst.

Reset
REQ-032 On rst at a clock edge, the block SHALL force IDLE, out=all rails 0, busy=0, done=0, ovf=0, proto_err=0, clear the synchronizer and history flops, and clear window and cnt.
REQ-033 On rst mid-run, the block SHALL abandon the token in flight; the receiver link phase SHALL be reset in the same cycle by the system.
REQ-034 On the first start after reset, the block SHALL restart the sequence from the seeds.

Verification
REQ-035 A bench SHALL check: WIDTH=8, ORDER=2, n_terms=10, receiver toggles ack 5 cycles after each token -> decoded tokens 0,1,1,2,3,5,8,13,21,34; done pulses once; ovf=0.
REQ-036 A bench SHALL check: WIDTH=8, ORDER=2, SAT=0, n_terms=16 -> token 14 = 121 and ovf=1; with SAT=1 -> tokens 14 and 15 = 255.
REQ-037 A bench SHALL check: ORDER=3, n_terms=7 -> tokens 0,0,1,1,2,4,7; busy falls on the cycle after the done pulse.
REQ-038 A bench SHALL check: ack withheld for 100 cycles -> out is stable; ack toggled -> out changes exactly 3 edges after the capture edge.
REQ-039 A bench SHALL check: rst asserted after the 4th token -> all rails 0, busy=0; a new start with n_terms=3 -> tokens 0,1,1.
REQ-040 A bench SHALL check: n_terms=0 start -> no rail toggle and one done pulse; start while busy -> ignored; ack toggle in IDLE -> proto_err=1.
